// File: rtl/multiplier_pkg.sv
// Shared types and constants for the Booth multiplier datapath and its BCD output stage.
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } conv_state_e;

  localparam logic [3:0] BCD_CORRECTION_THRESHOLD = 4'd5;
  localparam logic [3:0] BCD_CORRECTION           = 4'd3;

  function automatic int product_width(input int word_length);
    return 2 * word_length;
  endfunction

  function automatic int counter_width(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

endpackage

// File: rtl/Register.sv
// Enabled holding register with asynchronous active-low clear.
module Register #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3_digit
  import multiplier_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_CORRECTION_THRESHOLD) begin
      digit_o = digit_i + BCD_CORRECTION;
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Converts a signed product to sign + packed BCD magnitude, one double-dabble step per clock.
module product_bcd_converter
  import multiplier_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int BCD_DIGITS  = 5
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [product_width(WORD_LENGTH)-1:0]    Product_in,
  output logic                                     ready,
  output logic                                     done,
  output logic                                     Sign_out,
  output logic [4*BCD_DIGITS-1:0]                  Bcd_out
);

  localparam int P  = product_width(WORD_LENGTH);
  localparam int CW = counter_width(P);
  localparam int BW = 4 * BCD_DIGITS;

  conv_state_e   state_q;
  logic          ready_q;
  logic          done_q;
  logic          sign_q;
  logic [P-1:0]  mag_q;
  logic [BW-1:0] bcd_q;
  logic [CW-1:0] cnt_q;

  logic [P-1:0]  mag_in;
  logic [BW-1:0] corrected_w;
  logic [BW-1:0] bcd_d;
  logic [P-1:0]  mag_d;
  logic          last_iter;

  // Unary minus of the most-negative value wraps to 2^(P-1), which is the correct unsigned magnitude.
  assign mag_in    = Product_in[P-1] ? (-Product_in) : Product_in;
  assign last_iter = (state_q == CONVERT) && (cnt_q == CW'(P - 1));

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (corrected_w[4*g +: 4])
    );
  end

  // The top corrected bit shifts out of the working register and is dropped.
  always_comb begin
    bcd_d = BW'({corrected_w, mag_q[P-1]});
    mag_d = {mag_q[P-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            sign_q  <= Product_in[P-1];
            mag_q   <= mag_in;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_q <= bcd_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  Register #(.WIDTH(BW)) u_bcd_reg (
    .clk   (clk),
    .reset (reset),
    .en    (last_iter),
    .d     (bcd_d),
    .q     (Bcd_out)
  );

  Register #(.WIDTH(1)) u_sign_reg (
    .clk   (clk),
    .reset (reset),
    .en    (last_iter),
    .d     (sign_q),
    .q     (Sign_out)
  );

  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomised and directed checks of the product BCD converter against an arithmetic model.
module tb_product_bcd_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] Product_in;
  logic        ready;
  logic        done;
  logic        Sign_out;
  logic [19:0] Bcd_out;

  int total = 0;
  int bad   = 0;
  logic [19:0] last_bcd;

  always #5 clk = ~clk;

  product_bcd_converter #(.WORD_LENGTH(8), .BCD_DIGITS(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .Product_in (Product_in),
    .ready      (ready),
    .done       (done),
    .Sign_out   (Sign_out),
    .Bcd_out    (Bcd_out)
  );

  function automatic logic [19:0] ref_bcd(input int value);
    logic [19:0] r;
    int v;
    v = (value < 0) ? -value : value;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic run_conv(input logic [15:0] p, output logic [19:0] b, output logic s,
                          output int lat, output logic rdy_d, output logic done_n,
                          output logic rdy_n, output logic [19:0] mid_bcd);
    int k;
    k = 0;
    @(negedge clk);
    while (ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    start = 1'b1;
    Product_in = p;
    @(negedge clk);
    start = 1'b0;
    Product_in = 16'($urandom);
    k = 1;
    mid_bcd = 'x;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 8) mid_bcd = Bcd_out;
    end
    lat = k;
    b = Bcd_out;
    s = Sign_out;
    rdy_d = ready;
    @(negedge clk);
    done_n = done;
    rdy_n = ready;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    Product_in = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({ready, done, Sign_out, Bcd_out} !== {1'b1, 1'b0, 1'b0, 20'h0}) begin
      bad++;
      $display("FAIL reset_state: got ready=%b done=%b sign=%b bcd=%h, want 1 0 0 00000",
               ready, done, Sign_out, Bcd_out);
    end
    reset = 1'b1;
    last_bcd = '0;
  endtask

  task automatic test_directed;
    logic [15:0] table_p [7] = '{16'h3F01, 16'hFFFF, 16'hC000, 16'h8000, 16'h0000, 16'h0001, 16'h7FFF};
    logic [19:0] b, mid;
    logic s, rd, dn, rn;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_conv(table_p[i], b, s, lat, rd, dn, rn, mid);
      total++;
      if (b !== ref_bcd(int'($signed(table_p[i]))) || s !== table_p[i][15]) begin
        bad++;
        $display("FAIL directed_value p=%h: got sign=%b bcd=%h, want sign=%b bcd=%h",
                 table_p[i], s, b, table_p[i][15], ref_bcd(int'($signed(table_p[i]))));
      end
      total++;
      if (lat != 17 || rd !== 1'b0) begin
        bad++;
        $display("FAIL directed_latency p=%h: got lat=%0d ready=%b, want lat=17 ready=0",
                 table_p[i], lat, rd);
      end
      total++;
      if (dn !== 1'b0 || rn !== 1'b1) begin
        bad++;
        $display("FAIL directed_done_pulse p=%h: got done=%b ready=%b after pulse, want 0 1",
                 table_p[i], dn, rn);
      end
      total++;
      if (mid !== last_bcd) begin
        bad++;
        $display("FAIL directed_hold p=%h: got bcd=%h mid-conversion, want %h", table_p[i], mid, last_bcd);
      end
      last_bcd = ref_bcd(int'($signed(table_p[i])));
    end
  endtask

  task automatic test_reset_abort;
    int dones;
    @(negedge clk);
    start = 1'b1;
    Product_in = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({ready, done, Sign_out, Bcd_out} !== {1'b1, 1'b0, 1'b0, 20'h0}) begin
      bad++;
      $display("FAIL reset_abort: got ready=%b done=%b sign=%b bcd=%h, want 1 0 0 00000",
               ready, done, Sign_out, Bcd_out);
    end
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL reset_no_done: got %0d done pulses after reset, want 0", dones);
    end
    last_bcd = '0;
  endtask

  task automatic test_ignore;
    int k;
    int extra;
    @(negedge clk);
    start = 1'b1;
    Product_in = 16'hF000;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 6) begin
        start = 1'b1;
        Product_in = 16'h0101;
      end else if (k == 7) begin
        start = 1'b0;
      end
    end
    start = 1'b1;
    Product_in = 16'h2222;
    total++;
    if (k != 17 || Bcd_out !== 20'h04096 || Sign_out !== 1'b1) begin
      bad++;
      $display("FAIL ignore_in_convert: got lat=%0d sign=%b bcd=%h, want 17 1 04096", k, Sign_out, Bcd_out);
    end
    @(negedge clk);
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    total++;
    if (extra != 0 || ready !== 1'b1 || Bcd_out !== 20'h04096) begin
      bad++;
      $display("FAIL ignore_in_done: got extra=%0d ready=%b bcd=%h, want 0 1 04096", extra, ready, Bcd_out);
    end
  endtask

  task automatic test_back_to_back;
    int pulses[$];
    int wrong;
    @(negedge clk);
    start = 1'b1;
    Product_in = 16'hFF38;
    wrong = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses.push_back(c);
        if (Bcd_out !== 20'h00200 || Sign_out !== 1'b1) wrong++;
      end
    end
    start = 1'b0;
    total++;
    if (pulses.size() != 6 || wrong != 0) begin
      bad++;
      $display("FAIL b2b_count: got pulses=%0d wrong=%0d, want 6 0", pulses.size(), wrong);
    end
    for (int i = 1; i < pulses.size(); i++) begin
      total++;
      if (pulses[i] - pulses[i-1] != 18) begin
        bad++;
        $display("FAIL b2b_interval %0d: got %0d cycles, want 18", i, pulses[i] - pulses[i-1]);
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_random;
    logic [19:0] b, mid;
    logic s, rd, dn, rn;
    int lat, a, m, prod, errs;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom_range(0, 255);
      m = $urandom_range(0, 255);
      if (a > 127) a -= 256;
      if (m > 127) m -= 256;
      prod = a * m;
      run_conv(16'(prod), b, s, lat, rd, dn, rn, mid);
      total++;
      if (b !== ref_bcd(prod) || s !== (prod < 0) || lat != 17) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL random %0d*%0d: got sign=%b bcd=%h lat=%0d, want sign=%b bcd=%h lat=17",
                   a, m, s, b, lat, prod < 0, ref_bcd(prod));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_ignore();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
